// File: rtl/ece453_debounce_irq_if.sv
// ----------------------------------------------------------------------------
// ece453_debounce_irq_if
// Avalon-MM slave bus bundle for the debounce/interrupt block.
//   slave_address    : word address (5 bits)
//   slave_read       : read strobe
//   slave_write      : write strobe
//   slave_writedata  : write data (32 bits)
//   slave_byteenable : per-byte write enables (4 bits)
//   slave_readdata   : combinational read data (32 bits)
// Modports: master drives the request side, slave returns read data.
// ----------------------------------------------------------------------------
interface ece453_debounce_irq_if;
  logic [4:0]  slave_address;
  logic        slave_read;
  logic        slave_write;
  logic [31:0] slave_writedata;
  logic [3:0]  slave_byteenable;
  logic [31:0] slave_readdata;

  modport master (
    output slave_address, slave_read, slave_write, slave_writedata, slave_byteenable,
    input  slave_readdata
  );

  modport slave (
    input  slave_address, slave_read, slave_write, slave_writedata, slave_byteenable,
    output slave_readdata
  );
endinterface

// File: rtl/ece453_debounce_irq.sv
// ----------------------------------------------------------------------------
// ece453_debounce_irq
// Multi-channel button/switch debouncer with edge-triggered sticky interrupts
// behind an Avalon-MM register file.
// Ports:
//   clk           : single rising-edge clock
//   reset_n       : asynchronous active-low reset
//   bus           : Avalon-MM slave (ece453_debounce_irq_if.slave)
//   gpio_inputs   : raw asynchronous input lines (CHANNELS bits)
//   debounced_out : accepted stable levels (same as STATUS)
//   irq_out       : |(IM & IRQ)
// Register map (word address): 0 DEV_ID, 1 CONTROL(bit0 ENABLE), 2 STATUS,
//   3 IM, 4 IRQ (W1C), 5 RISE_EN, 6 FALL_EN, 7 RAW.
// ----------------------------------------------------------------------------
module ece453_debounce_irq #(
  parameter int CHANNELS = 8,
  parameter int TICK_DIV = 500000,
  parameter int SAMPLES  = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  ece453_debounce_irq_if.slave bus,
  input  logic [CHANNELS-1:0] gpio_inputs,
  output logic [CHANNELS-1:0] debounced_out,
  output logic                irq_out
);

  localparam logic [31:0] DEV_ID      = 32'hECE45320;
  localparam logic [23:0] TICK_RELOAD = 24'(TICK_DIV - 1);
  localparam logic [3:0]  SAMPLES_C   = 4'(SAMPLES);

  localparam logic [4:0] A_DEVID  = 5'd0;
  localparam logic [4:0] A_CTRL   = 5'd1;
  localparam logic [4:0] A_STATUS = 5'd2;
  localparam logic [4:0] A_IM     = 5'd3;
  localparam logic [4:0] A_IRQ    = 5'd4;
  localparam logic [4:0] A_RISE   = 5'd5;
  localparam logic [4:0] A_FALL   = 5'd6;
  localparam logic [4:0] A_RAW    = 5'd7;

  logic [CHANNELS-1:0] sync1_q, sync2_q;
  logic [CHANNELS-1:0] stable_q, stable_d;
  logic [CHANNELS-1:0] stable_dly_q;
  logic [CHANNELS-1:0] im_q, im_d;
  logic [CHANNELS-1:0] irq_q, irq_d;
  logic [CHANNELS-1:0] rise_en_q, rise_en_d;
  logic [CHANNELS-1:0] fall_en_q, fall_en_d;
  logic                enable_q, enable_d;
  logic [23:0]         tick_cnt_q, tick_cnt_d;
  logic [3:0]          run_q [CHANNELS];
  logic [3:0]          run_d [CHANNELS];

  logic                tick;
  logic [CHANNELS-1:0] be_mask;
  logic [CHANNELS-1:0] wdata_ch;
  logic [CHANNELS-1:0] irq_set, irq_clr;

  // Byte-lane merge: only lanes with their byteenable set take new data.
  function automatic logic [CHANNELS-1:0] merge_bytes(
    input logic [CHANNELS-1:0] old_v,
    input logic [CHANNELS-1:0] new_v,
    input logic [CHANNELS-1:0] mask
  );
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  always_comb begin
    be_mask  = '0;
    wdata_ch = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      be_mask[i]  = bus.slave_byteenable[i / 8];
      wdata_ch[i] = bus.slave_writedata[i];
    end
  end

  // Tick is a single-cycle strobe while the down-counter sits at zero.
  assign tick = enable_q && (tick_cnt_q == 24'd0);

  always_comb begin
    tick_cnt_d = tick_cnt_q;
    stable_d   = stable_q;
    run_d      = run_q;
    enable_d   = enable_q;
    im_d       = im_q;
    rise_en_d  = rise_en_q;
    fall_en_d  = fall_en_q;
    irq_clr    = '0;

    if (!enable_q || tick) tick_cnt_d = TICK_RELOAD;
    else                   tick_cnt_d = tick_cnt_q - 24'd1;

    for (int i = 0; i < CHANNELS; i++) begin
      if (!enable_q) begin
        run_d[i] = '0;
      end else if (tick) begin
        // A matching sample kills the run, so short glitches never qualify.
        if (sync2_q[i] == stable_q[i]) begin
          run_d[i] = '0;
        end else if (run_q[i] + 4'd1 == SAMPLES_C) begin
          stable_d[i] = ~stable_q[i];
          run_d[i]    = '0;
        end else begin
          run_d[i] = run_q[i] + 4'd1;
        end
      end
    end

    if (bus.slave_write) begin
      case (bus.slave_address)
        A_CTRL: if (bus.slave_byteenable[0]) enable_d = bus.slave_writedata[0];
        A_IM:   im_d      = merge_bytes(im_q, wdata_ch, be_mask);
        A_IRQ:  irq_clr   = wdata_ch & be_mask;
        A_RISE: rise_en_d = merge_bytes(rise_en_q, wdata_ch, be_mask);
        A_FALL: fall_en_d = merge_bytes(fall_en_q, wdata_ch, be_mask);
        default: ;
      endcase
    end

    // Set wins over a same-cycle write-1-to-clear.
    irq_set = enable_q ? ((stable_q & ~stable_dly_q & rise_en_q) |
                          (~stable_q & stable_dly_q & fall_en_q)) : '0;
    irq_d   = (irq_q & ~irq_clr) | irq_set;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      stable_q     <= '0;
      stable_dly_q <= '0;
      im_q         <= '0;
      irq_q        <= '0;
      rise_en_q    <= '0;
      fall_en_q    <= '0;
      enable_q     <= 1'b0;
      tick_cnt_q   <= TICK_RELOAD;
      for (int i = 0; i < CHANNELS; i++) run_q[i] <= '0;
    end else begin
      sync1_q      <= gpio_inputs;
      sync2_q      <= sync1_q;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      im_q         <= im_d;
      irq_q        <= irq_d;
      rise_en_q    <= rise_en_d;
      fall_en_q    <= fall_en_d;
      enable_q     <= enable_d;
      tick_cnt_q   <= tick_cnt_d;
      run_q        <= run_d;
    end
  end

  always_comb begin
    bus.slave_readdata = '0;
    if (bus.slave_read) begin
      case (bus.slave_address)
        A_DEVID:  bus.slave_readdata = DEV_ID;
        A_CTRL:   bus.slave_readdata = {31'd0, enable_q};
        A_STATUS: bus.slave_readdata = 32'(stable_q);
        A_IM:     bus.slave_readdata = 32'(im_q);
        A_IRQ:    bus.slave_readdata = 32'(irq_q);
        A_RISE:   bus.slave_readdata = 32'(rise_en_q);
        A_FALL:   bus.slave_readdata = 32'(fall_en_q);
        A_RAW:    bus.slave_readdata = 32'(sync2_q);
        default:  bus.slave_readdata = '0;
      endcase
    end
  end

  assign debounced_out = stable_q;
  assign irq_out       = |(im_q & irq_q);

endmodule

// File: tb/tb_ece453_debounce_irq.sv
// ----------------------------------------------------------------------------
// tb_ece453_debounce_irq
// Directed bench for ece453_debounce_irq (CHANNELS=4, TICK_DIV=4, SAMPLES=3).
// A behavioural model tracks enabled-cycle counts, per-channel run lengths and
// register contents; it is compared with the DUT every cycle, and directed
// steps add hand-computed literal expectations.
// ----------------------------------------------------------------------------
module tb_ece453_debounce_irq;
  localparam int CH = 4;
  localparam int TD = 4;
  localparam int SM = 3;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [CH-1:0] gpio;
  logic [CH-1:0] dbo;
  logic          irq;

  ece453_debounce_irq_if bus();

  ece453_debounce_irq #(.CHANNELS(CH), .TICK_DIV(TD), .SAMPLES(SM)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .bus           (bus),
    .gpio_inputs   (gpio),
    .debounced_out (dbo),
    .irq_out       (irq)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  int unsigned m_ctrl, m_im, m_irq, m_rise, m_fall, m_stab, m_prev, m_s1, m_raw;
  int          m_run [CH];
  int          m_en;

  function automatic int unsigned lane_mask(input logic [3:0] be);
    int unsigned m = 0;
    for (int b = 0; b < 4; b++) if (be[b]) m |= (32'hFF << (8 * b));
    return m & 32'hF;
  endfunction

  task automatic model_step();
    int unsigned o_stab, o_prev, o_raw, o_ctrl, o_rise, o_fall, mk, wd, set_v, clr_v;
    bit tick;
    if (!reset_n) begin
      m_ctrl = 0; m_im = 0; m_irq = 0; m_rise = 0; m_fall = 0;
      m_stab = 0; m_prev = 0; m_s1 = 0; m_raw = 0; m_en = 0;
      for (int i = 0; i < CH; i++) m_run[i] = 0;
    end else begin
      o_stab = m_stab; o_prev = m_prev; o_raw = m_raw; o_ctrl = m_ctrl;
      o_rise = m_rise; o_fall = m_fall;
      // one tick per TD consecutive enabled clocks, counted from enable
      tick = (o_ctrl != 0) && (((m_en + 1) % TD) == 0);
      m_en = (o_ctrl != 0) ? m_en + 1 : 0;
      for (int i = 0; i < CH; i++) begin
        if (o_ctrl == 0) m_run[i] = 0;
        else if (tick) begin
          if (((o_raw >> i) & 1) == ((o_stab >> i) & 1)) m_run[i] = 0;
          else if (m_run[i] + 1 == SM) begin
            m_stab = m_stab ^ (32'd1 << i);
            m_run[i] = 0;
          end else m_run[i] = m_run[i] + 1;
        end
      end
      set_v = (o_ctrl != 0) ? (((o_stab & ~o_prev & o_rise) | (~o_stab & o_prev & o_fall)) & 32'hF) : 0;
      clr_v = 0;
      mk = lane_mask(bus.slave_byteenable);
      wd = bus.slave_writedata;
      if (bus.slave_write) begin
        case (bus.slave_address)
          5'd1: if (bus.slave_byteenable[0]) m_ctrl = wd & 1;
          5'd3: m_im   = (m_im & ~mk) | (wd & mk);
          5'd4: clr_v  = wd & mk;
          5'd5: m_rise = (m_rise & ~mk) | (wd & mk);
          5'd6: m_fall = (m_fall & ~mk) | (wd & mk);
          default: ;
        endcase
      end
      m_irq  = (m_irq & ~clr_v) | set_v;
      m_prev = o_stab;
      m_raw  = m_s1;
      m_s1   = 32'(gpio);
    end
  endtask

  function automatic logic [31:0] m_rdata();
    if (!bus.slave_read) return 32'd0;
    case (bus.slave_address)
      5'd0: return 32'hECE45320;
      5'd1: return m_ctrl;
      5'd2: return m_stab;
      5'd3: return m_im;
      5'd4: return m_irq;
      5'd5: return m_rise;
      5'd6: return m_fall;
      5'd7: return m_raw;
      default: return 32'd0;
    endcase
  endfunction

  // Inputs change at negedge+1, so at each negedge they still hold the
  // values the DUT sampled on the preceding rising edge.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      model_step();
      check("cyc_debounced", 32'(dbo), m_stab);
      check("cyc_irq_out", 32'(irq), 32'((m_im & m_irq) != 0));
      check("cyc_readdata", bus.slave_readdata, m_rdata());
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    bus.slave_address    = a;
    bus.slave_writedata  = d;
    bus.slave_byteenable = 4'hF;
    bus.slave_write      = 1'b1;
    step();
    bus.slave_write      = 1'b0;
  endtask

  task automatic rd_chk(input string nm, input logic [4:0] a, input logic [31:0] exp);
    bus.slave_address = a;
    bus.slave_read    = 1'b1;
    #1;
    check(nm, bus.slave_readdata, exp);
    step();
    bus.slave_read    = 1'b0;
  endtask

  // Counts falling edges until (dbo & mask) == val, bounded at 100.
  task automatic wait_dbo(input logic [3:0] mask, input logic [3:0] val, output int k);
    k = 0;
    while (((dbo & mask) != val) && k < 100) begin
      @(negedge clk);
      k++;
    end
    #1;
  endtask

  int k;

  initial begin
    reset_n = 1'b1;
    gpio = '0;
    bus.slave_address = '0; bus.slave_read = 1'b0; bus.slave_write = 1'b0;
    bus.slave_writedata = '0; bus.slave_byteenable = '0;
    #1 reset_n = 1'b0;
    chk_en = 1'b1;
    repeat (3) step();
    reset_n = 1'b1;
    step();

    // reset state
    rd_chk("devid", 5'd0, 32'hECE45320);
    rd_chk("status_rst", 5'd2, 32'h0);
    rd_chk("irq_rst", 5'd4, 32'h0);
    check("irq_out_rst", 32'(irq), 32'd0);

    // ch0 rise qualification and interrupt
    wr(5'd1, 32'h1);
    wr(5'd5, 32'h1);
    wr(5'd3, 32'h1);
    gpio = 4'b0001;
    wait_dbo(4'h1, 4'h1, k);
    check("rise_latency", 32'(k), 32'd14);
    check("status_after_rise", 32'(dbo), 32'h1);
    step();
    check("irq_out_rise", 32'(irq), 32'd1);
    rd_chk("irq_rise", 5'd4, 32'h1);

    // 6-clock glitch on ch1 is rejected
    gpio = 4'b0011;
    repeat (6) step();
    gpio = 4'b0001;
    repeat (20) step();
    check("glitch_rejected", 32'(dbo), 32'h1);
    rd_chk("irq_after_glitch", 5'd4, 32'h1);

    // clear colliding with a new fall event keeps the flag
    wr(5'd6, 32'h1);
    gpio = 4'b0000;
    wait_dbo(4'h1, 4'h0, k);
    check("fall_status", 32'(dbo), 32'h0);
    wr(5'd4, 32'h1);
    rd_chk("irq_set_wins", 5'd4, 32'h1);
    wr(5'd4, 32'h1);
    rd_chk("irq_cleared", 5'd4, 32'h0);
    check("irq_out_cleared", 32'(irq), 32'd0);

    // disable mid-run on ch2, then re-enable from a clean count
    wr(5'd1, 32'h0);
    gpio = 4'b0100;
    repeat (5) step();
    wr(5'd1, 32'h1);
    repeat (8) step();
    wr(5'd1, 32'h0);
    check("ch2_partial", 32'(dbo), 32'h0);
    repeat (40) step();
    check("ch2_frozen", 32'(dbo), 32'h0);
    wr(5'd1, 32'h1);
    wait_dbo(4'h4, 4'h4, k);
    check("reenable_latency", 32'(k), 32'd12);

    // reset mid-run with STATUS=0xF, IRQ=0x3
    wr(5'd5, 32'h3);
    wr(5'd3, 32'hF);
    gpio = 4'hF;
    wait_dbo(4'hF, 4'hF, k);
    repeat (2) step();
    check("status_all", 32'(dbo), 32'hF);
    rd_chk("irq_pre_reset", 5'd4, 32'h3);
    check("irq_out_pre_reset", 32'(irq), 32'd1);
    reset_n = 1'b0;
    #1;
    check("dbo_in_reset", 32'(dbo), 32'h0);
    check("irq_out_in_reset", 32'(irq), 32'd0);
    rd_chk("irq_in_reset", 5'd4, 32'h0);
    reset_n = 1'b1;
    step();
    rd_chk("ctrl_after_reset", 5'd1, 32'h0);
    rd_chk("im_after_reset", 5'd3, 32'h0);
    rd_chk("rise_after_reset", 5'd5, 32'h0);
    rd_chk("status_after_reset", 5'd2, 32'h0);
    wr(5'd1, 32'h1);
    wait_dbo(4'hF, 4'hF, k);
    check("requalify_latency", 32'(k), 32'd12);
    repeat (2) step();
    rd_chk("irq_after_requal", 5'd4, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
